plate_generator: RTL and testbench

Sequential licence-plate generator: the producing end of the plate format that the combinational plate validator checks. A plate is six 4-bit symbols m0..m5 grouped into pairs (m0,m1), (m2,m3), (m4,m5). A symbol ≥ 4'hA is a letter and a symbol ≤ 4'h9 is a digit. A plate is valid when each pair is pure digits or pure letters and not all three pairs are letters. The block loads a seed plate, checks it, then emits every following valid plate in fixed enumeration order over a valid/ready handshake. Its output feeds the validator and the plate registers directly.

---
 rtl/plate_generator.sv | 136 +++++++++++++
 tb/tb_plate_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/plate_generator.sv
// rtl/plate_generator.sv - seeded licence-plate sequence generator with valid/ready output
// Plate m0..m5 (m0 most significant); letters are symbols >= 4'hA, digits <= 4'h9.
module plate_generator #(
  parameter bit WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] seed0,
  input  logic [3:0] seed1,
  input  logic [3:0] seed2,
  input  logic [3:0] seed3,
  input  logic [3:0] seed4,
  input  logic [3:0] seed5,
  input  logic       stop,
  input  logic       out_ready,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] m2,
  output logic [3:0] m3,
  output logic [3:0] m4,
  output logic [3:0] m5,
  output logic       out_valid,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0][3:0] m_q, m_d;
  logic            err_q, err_d;
  logic [5:0][3:0] seed;
  logic [5:0][3:0] nxt;
  logic            carry;
  logic            seed_ok;
  logic            last;
  logic [2:0]      fmt;
  logic [2:0]      fmt_next;

  function automatic logic is_letter(input logic [3:0] s);
    return s >= 4'hA;
  endfunction

  assign seed = {seed5, seed4, seed3, seed2, seed1, seed0};

  always_comb begin
    seed_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (is_letter(seed[2*k]) != is_letter(seed[2*k+1])) seed_ok = 1'b0;
    end
    if (is_letter(seed[0]) && is_letter(seed[2]) && is_letter(seed[4])) seed_ok = 1'b0;
  end

  // Ripple increment from m5 toward m0; a carry out of m0 moves to the next format.
  always_comb begin
    nxt      = m_q;
    carry    = 1'b1;
    fmt      = {is_letter(m_q[0]), is_letter(m_q[2]), is_letter(m_q[4])};
    fmt_next = fmt + 3'd1;
    for (int i = 5; i >= 0; i--) begin
      if (carry) begin
        if (is_letter(m_q[i])) begin
          if (m_q[i] == 4'hF) nxt[i] = 4'hA;
          else begin
            nxt[i] = m_q[i] + 4'd1;
            carry  = 1'b0;
          end
        end else begin
          if (m_q[i] == 4'h9) nxt[i] = 4'h0;
          else begin
            nxt[i] = m_q[i] + 4'd1;
            carry  = 1'b0;
          end
        end
      end
    end
    if (carry) begin
      for (int k = 0; k < 3; k++) begin
        nxt[2*k]   = fmt_next[2-k] ? 4'hA : 4'h0;
        nxt[2*k+1] = fmt_next[2-k] ? 4'hA : 4'h0;
      end
    end
    last = carry && (fmt == 3'd6);
    if (last) nxt = '0;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    err_d   = err_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            if (seed_ok) begin
              m_d     = seed;
              err_d   = 1'b0;
              state_d = RUN;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last && !WRAP) state_d = DONE;
            else               m_d     = nxt;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      err_q   <= err_d;
    end
  end

  assign {m5, m4, m3, m2, m1, m0} = m_q;
  assign out_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_plate_generator.sv
// tb/tb_plate_generator.sv - directed self-checking bench for plate_generator
// Two instances share stimulus: dut0 stops at the last plate, dut1 wraps.
module tb_plate_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       stop = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] seed0 = '0, seed1 = '0, seed2 = '0, seed3 = '0, seed4 = '0, seed5 = '0;

  logic [3:0] a_m0, a_m1, a_m2, a_m3, a_m4, a_m5;
  logic [3:0] b_m0, b_m1, b_m2, b_m3, b_m4, b_m5;
  logic       a_valid, a_done, a_err;
  logic       b_valid, b_done, b_err;
  logic [23:0] plate_a, plate_b;

  int total = 0;
  int passed = 0;
  int fails = 0;

  assign plate_a = {a_m0, a_m1, a_m2, a_m3, a_m4, a_m5};
  assign plate_b = {b_m0, b_m1, b_m2, b_m3, b_m4, b_m5};

  always #5 clk = ~clk;

  plate_generator #(.WRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .seed0(seed0), .seed1(seed1), .seed2(seed2), .seed3(seed3), .seed4(seed4), .seed5(seed5),
    .stop(stop), .out_ready(out_ready),
    .m0(a_m0), .m1(a_m1), .m2(a_m2), .m3(a_m3), .m4(a_m4), .m5(a_m5),
    .out_valid(a_valid), .done(a_done), .err(a_err)
  );

  plate_generator #(.WRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .seed0(seed0), .seed1(seed1), .seed2(seed2), .seed3(seed3), .seed4(seed4), .seed5(seed5),
    .stop(stop), .out_ready(out_ready),
    .m0(b_m0), .m1(b_m1), .m2(b_m2), .m3(b_m3), .m4(b_m4), .m5(b_m5),
    .out_valid(b_valid), .done(b_done), .err(b_err)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seed(input logic [23:0] s);
    {seed0, seed1, seed2, seed3, seed4, seed5} = s;
  endtask

  task automatic do_load(input logic [23:0] s);
    set_seed(s);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("reset_plate", plate_a, 24'h000000);
    chk("reset_valid", {23'd0, a_valid}, 24'd0);
    chk("reset_done", {23'd0, a_done}, 24'd0);
    chk("reset_err", {23'd0, a_err}, 24'd0);
    rst_n = 1'b1;
    step();

    out_ready = 1'b1;
    do_load(24'h000000);
    chk("load0_plate", plate_a, 24'h000000);
    chk("load0_valid", {23'd0, a_valid}, 24'd1);
    step();
    chk("count_1", plate_a, 24'h000001);
    for (int i = 2; i <= 9; i++) step();
    chk("count_9", plate_a, 24'h000009);
    step();
    chk("count_10", plate_a, 24'h000010);
    chk("count_valid", {23'd0, a_valid}, 24'd1);

    do_stop();
    chk("stop_plate", plate_a, 24'h000010);
    chk("stop_valid", {23'd0, a_valid}, 24'd0);
    step();
    chk("stop_hold", plate_a, 24'h000010);

    out_ready = 1'b0;
    do_load(24'h123456);
    chk("stall_load", plate_a, 24'h123456);
    step(); step(); step();
    chk("stall_plate", plate_a, 24'h123456);
    chk("stall_valid", {23'd0, a_valid}, 24'd1);
    out_ready = 1'b1;
    step();
    chk("stall_release", plate_a, 24'h123457);
    out_ready = 1'b0;

    do_stop();
    do_load(24'h999999);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("carry_fmt0to1", plate_a, 24'h0000AA);

    do_stop();
    do_load(24'h0000FF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("carry_letters", plate_a, 24'h0001AA);

    do_stop();
    do_load(24'h0999AF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("carry_low_letter", plate_a, 24'h0999BA);

    do_stop();
    do_load(24'hA10000);
    chk("bad_mixed_err", {23'd0, a_err}, 24'd1);
    chk("bad_mixed_valid", {23'd0, a_valid}, 24'd0);
    chk("bad_mixed_plate", plate_a, 24'h0999BA);
    do_load(24'hAAAAAA);
    chk("bad_letters_err", {23'd0, a_err}, 24'd1);
    chk("bad_letters_valid", {23'd0, a_valid}, 24'd0);
    do_load(24'h000000);
    chk("recover_err", {23'd0, a_err}, 24'd0);
    chk("recover_valid", {23'd0, a_valid}, 24'd1);

    do_stop();
    do_load(24'hFFFF99);
    chk("last_load", plate_a, 24'hFFFF99);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("last_done", {23'd0, a_done}, 24'd1);
    chk("last_valid", {23'd0, a_valid}, 24'd0);
    chk("wrap_plate", plate_b, 24'h000000);
    chk("wrap_valid", {23'd0, b_valid}, 24'd1);
    do_load(24'h55ABCD);
    chk("restart_plate", plate_a, 24'h55ABCD);
    chk("restart_done", {23'd0, a_done}, 24'd0);
    chk("restart_valid", {23'd0, a_valid}, 24'd1);

    do_stop();
    set_seed(24'h111111);
    load = 1'b1;
    stop = 1'b1;
    step();
    load = 1'b0;
    stop = 1'b0;
    chk("loadstop_plate", plate_a, 24'h55ABCD);
    chk("loadstop_valid", {23'd0, a_valid}, 24'd0);

    out_ready = 1'b1;
    do_load(24'h000000);
    step(); step(); step();
    chk("prereset_plate", plate_a, 24'h000003);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_plate", plate_a, 24'h000000);
    chk("async_valid", {23'd0, a_valid}, 24'd0);
    chk("async_done", {23'd0, a_done}, 24'd0);
    chk("async_err", {23'd0, a_err}, 24'd0);
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
